// File: rtl/pwd_candidate_streamer.sv
// pwd_candidate_streamer: brute-force candidate generator feeding the top_sha byte interface
// Enumerates every string over CHAR_FIRST..CHAR_LAST, lengths 1..MAX_LEN, in odometer order.
// Ports: clk, rst (async active-low); start (begin enumeration in IDLE/DONE), abort (to IDLE),
// hash_done (digest consumed); byte_rdy/byte_stop/data_out to top_sha; cand/cand_len current
// candidate (byte 0 in [7:0]); busy (SEND/STOP/ADV); exhausted (DONE).
module pwd_candidate_streamer #(
  parameter int MAX_LEN = 4,
  parameter logic [7:0] CHAR_FIRST = 8'h61,
  parameter logic [7:0] CHAR_LAST = 8'h7A,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int CW = 8 * MAX_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          hash_done,
  output logic          byte_rdy,
  output logic          byte_stop,
  output logic [7:0]    data_out,
  output logic [CW-1:0] cand,
  output logic [LW-1:0] cand_len,
  output logic          busy,
  output logic          exhausted
);
  typedef enum logic [2:0] {IDLE, SEND, STOP, ADV, DONE} state_t;
  state_t state, nstate;
  logic [LW-1:0] idx, inc_len;
  logic [CW-1:0] inc;
  logic carry, last;
  // Odometer increment: last byte is least significant; a full carry grows the length.
  always_comb begin
    inc = cand;
    inc_len = cand_len;
    carry = 1'b1;
    last = cand_len == LW'(MAX_LEN);
    for (int i = MAX_LEN - 1; i >= 0; i--)
      if (LW'(i) < cand_len) begin
        last = last & (cand[8*i +: 8] == CHAR_LAST);
        inc[8*i +: 8] = carry ? (cand[8*i +: 8] == CHAR_LAST ? CHAR_FIRST : cand[8*i +: 8] + 8'd1) : cand[8*i +: 8];
        carry = carry & (cand[8*i +: 8] == CHAR_LAST);
      end
    if (carry) begin
      inc_len = cand_len + LW'(1);
      for (int i = 0; i < MAX_LEN; i++) inc[8*i +: 8] = LW'(i) <= cand_len ? CHAR_FIRST : 8'h00;
    end
  end
  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = start ? SEND : IDLE;
      SEND: nstate = abort ? IDLE : (idx == cand_len - LW'(1) ? STOP : SEND);
      STOP: nstate = abort ? IDLE : (hash_done ? (last ? DONE : ADV) : STOP);
      ADV:  nstate = abort ? IDLE : SEND;
      DONE: nstate = abort ? IDLE : (start ? SEND : DONE);
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cand <= '0;
      cand_len <= '0;
      idx <= '0;
    end else begin
      state <= nstate;
      idx <= (state == SEND && nstate == SEND) ? idx + LW'(1) : '0;
      if ((state == IDLE || state == DONE) && nstate == SEND) begin
        cand <= CW'(CHAR_FIRST);
        cand_len <= LW'(1);
      end else if (state == ADV && nstate == SEND) begin
        cand <= inc;
        cand_len <= inc_len;
      end
    end
  end
  assign byte_rdy = state == SEND;
  assign byte_stop = state == STOP;
  assign data_out = state == SEND ? 8'(cand >> (8 * idx)) : 8'h00;
  assign busy = state == SEND || state == STOP || state == ADV;
  assign exhausted = state == DONE;
endmodule

// File: doc/pwd_candidate_streamer.md
Name: pwd_candidate_streamer

Overview:
Brute-force candidate generator that sits directly upstream of top_sha. It enumerates every string over a contiguous byte charset, from length 1 up to MAX_LEN, in odometer order. Each candidate is serialized into top_sha's byte interface (byte_rdy/byte_stop/data_in). The block waits for the hash-complete pulse before advancing, and exposes the current candidate for the downstream match/report logic.

Parameters:
MAX_LEN, 4, maximum candidate length in bytes (1..8)
CHAR_FIRST, 8'h61, first charset byte ('a')
CHAR_LAST, 8'h7A, last charset byte ('z'); must be >= CHAR_FIRST

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  pulse: begin enumeration from first candidate (honoured in IDLE/DONE only)
abort  input  1  level/pulse: stop enumeration (e.g. match found), return to IDLE
hash_done  input  1  pulse from hash path: digest for current candidate consumed
byte_rdy  output  1  data_out valid this cycle; drives top_sha byte_rdy
byte_stop  output  1  end of message; drives top_sha byte_stop
data_out  output  8  candidate byte; drives top_sha data_in
cand  output  8*MAX_LEN  current candidate, byte 0 (first sent) in bits [7:0], unused bytes 8'h00
cand_len  output  $clog2(MAX_LEN+1)  current candidate length
busy  output  1  high in SEND/STOP/ADV
exhausted  output  1  high in DONE (all candidates issued)

Behaviour:
- Reset (rst=0, async): state=IDLE; byte_rdy=0, byte_stop=0, data_out=0, cand=0, cand_len=0, busy=0, exhausted=0.
- States: IDLE, SEND, STOP, ADV, DONE.
- IDLE: on start, load cand={CHAR_FIRST} and cand_len=1, byte index=0, go to SEND.
- SEND: byte_rdy=1, data_out=cand byte[idx], on consecutive cycles for exactly cand_len cycles with no gaps. Then go to STOP. hash_done is ignored in SEND.
- STOP: byte_rdy=0, data_out=0, byte_stop=1 held every cycle until hash_done=1 is sampled.
  - If cand is the final candidate (length MAX_LEN, all bytes CHAR_LAST), go to DONE.
  - Otherwise go to ADV.
- ADV (1 cycle): byte_stop=0. Increment cand as a base-(CHAR_LAST-CHAR_FIRST+1) odometer. The last byte (index cand_len-1) is least significant.
  - A byte at CHAR_LAST wraps to CHAR_FIRST and carries toward byte 0.
  - Carry out of byte 0 sets cand_len+1 with all bytes = CHAR_FIRST.
  - Then go to SEND.
- DONE: exhausted=1, busy=0, all stream outputs 0, cand holds the final candidate. start restarts exactly as from IDLE (exhausted cleared).
- Order example (a..z): a, b, …, z, aa, ab, …, az, ba, …, zz, aaa, …
- Per-candidate latency: cand_len SEND cycles, then ≥1 STOP cycle, then 1 ADV cycle. The first byte_rdy is the cycle after start is sampled.
- cand/cand_len are stable from SEND entry through the end of STOP, so the downstream comparator may latch them on hash_done.
- abort sampled high in SEND/STOP/ADV/DONE: next state IDLE. All outputs go to reset values except that cand/cand_len are held for reporting.
  - abort wins over simultaneous hash_done and start.
  - abort in IDLE has no effect.
- start while busy is ignored.
- Reset asserted mid-stream clears immediately (async), with no partial byte_stop.
- Degenerate charset (CHAR_FIRST==CHAR_LAST): every byte wraps immediately, so the lengths 1..MAX_LEN are each issued once.

Test Plan:
- Reset release, start pulse → next 1 cycle byte_rdy=1 with data_out=8'h61, then byte_stop=1 held; no advance until hash_done; with hash_done → ADV, then data_out=8'h62 ("b").
- Hold hash_done response at 3 cycles latency for the "z" candidate → next candidate is cand_len=2: two byte_rdy cycles with data_out 8'h61, 8'h61; cand[15:0]=16'h6161.
- Carry check: reach "az" → next "ba" (bytes 8'h62, 8'h61); reach "zz" → "aaa", cand_len=3.
- MAX_LEN=2, auto-responder pulses hash_done 1 cycle after each byte_stop → exactly 702 byte_stop episodes, final cand=16'h7A7A, then exhausted=1, busy=0; start again → restarts at "a".
- Abort asserted in the same cycle as hash_done during STOP of "abc" → IDLE next cycle, byte_stop=0, cand still holds "abc", cand_len=3; no advance to "abd".
- Assert rst=0 mid-SEND of a 3-byte candidate → all outputs 0 asynchronously, state IDLE; after release, start → begins at "a".
- Integration with top_sha: stream "abc" → Hash_Digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, overflow_err=0.
